// File: rtl/hex_display_driver.sv
// hex_display_driver: drives six active-low 7-segment+DP digits from the PIO
// segment ports, adding frame-synchronous (tear-free) updates, PWM brightness
// and per-digit blink.
module hex_display_driver #(
    parameter int NUM_DIGITS   = 6,
    parameter int PRESCALE     = 500,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [8*NUM_DIGITS-1:0]   seg_in,
    input  logic                      update_req,
    input  logic [PWM_BITS-1:0]       brightness,
    input  logic                      blink_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [8*NUM_DIGITS-1:0]   seg_out,
    output logic                      update_ack,
    output logic                      frame_tick
);

    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0]       PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [FC_W-1:0]     FRAME_MAX = FC_W'(BLINK_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
    localparam logic [7:0]          SEG_RESET = 8'h40;
    localparam logic [7:0]          SEG_BLANK = 8'hFF;

    logic [PW-1:0]                  presc;
    logic [PWM_BITS-1:0]            pwm_cnt;
    logic [FC_W-1:0]                frame_cnt;
    logic                           blink_phase;
    logic                           pending;
    logic [PWM_BITS-1:0]            bright_active;
    logic [NUM_DIGITS-1:0][7:0]     staging;
    logic [NUM_DIGITS-1:0][7:0]     active;
    logic [NUM_DIGITS-1:0][7:0]     seg_next;

    logic tick;
    logic fb;
    logic pwm_on;

    assign tick   = (presc == PRESC_MAX);
    assign fb     = tick && (pwm_cnt == PWM_MAX);
    // Full-scale code bypasses the compare so it is truly always on.
    assign pwm_on = (bright_active == PWM_MAX) || (pwm_cnt < bright_active);

    // Timebase: prescaler producing PWM ticks, PWM counter wrapping naturally.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // Blink timebase: counts frames only while blinking is enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (fb && blink_en) begin
            if (frame_cnt == FRAME_MAX) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Double buffer: capture on request, commit to active at frame boundary.
    // A request landing on a boundary re-arms pending (set wins over clear).
    // NOTE: staging/active are reset explicitly because the reset pattern is
    // visible on the pins; plain data storage would normally be left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging       <= {NUM_DIGITS{SEG_RESET}};
            active        <= {NUM_DIGITS{SEG_RESET}};
            pending       <= 1'b0;
            bright_active <= PWM_MAX;
            update_ack    <= 1'b0;
            frame_tick    <= 1'b0;
        end else begin
            update_ack <= fb && pending;
            frame_tick <= fb;
            if (fb && pending) begin
                active <= staging;
            end
            if (fb) begin
                bright_active <= brightness;
            end
            if (update_req) begin
                staging <= seg_in;
                pending <= 1'b1;
            end else if (fb) begin
                pending <= 1'b0;
            end
        end
    end

    // Per-digit output gating: PWM off or blinking digit shows blank.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        seg_next = {NUM_DIGITS{SEG_BLANK}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pwm_on && !(blink_en && blink_mask[i] && blink_phase)) begin
                seg_next[i] = active[i];
            end
        end
    end

    // Output register: one cycle from internal state to the pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out <= '1;
        end else begin
            seg_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench for hex_display_driver: directed scenarios followed by
// randomized traffic, all compared cycle by cycle with a reference model that
// derives timing from the elapsed cycle count.
module tb_hex_display_driver;

    localparam int ND           = 6;
    localparam int PRESCALE     = 4;
    localparam int PWM_BITS     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int LEVELS       = 1 << PWM_BITS;
    localparam int FRAME        = PRESCALE * LEVELS;
    localparam int FULL         = LEVELS - 1;
    localparam logic [8*ND-1:0] ALL_BLANK = {ND{8'hFF}};
    localparam logic [8*ND-1:0] ALL_RESET = {ND{8'h40}};

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [8*ND-1:0]      seg_in = '0;
    logic                 update_req = 1'b0;
    logic [PWM_BITS-1:0]  brightness = 4'hF;
    logic                 blink_en = 1'b0;
    logic [ND-1:0]        blink_mask = '0;
    logic [8*ND-1:0]      seg_out;
    logic                 update_ack;
    logic                 frame_tick;

    hex_display_driver #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PRESCALE),
        .PWM_BITS     (PWM_BITS),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .update_req (update_req),
        .brightness (brightness),
        .blink_en   (blink_en),
        .blink_mask (blink_mask),
        .seg_out    (seg_out),
        .update_ack (update_ack),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int ack_seen = 0;

    // Reference model state: cycles since reset release, buffers, brightness,
    // and the number of frames counted while blinking was enabled.
    int              m_cycles;
    logic [8*ND-1:0] m_stage;
    logic [8*ND-1:0] m_active;
    logic [8*ND-1:0] m_seg;
    logic            m_pending;
    logic            m_ack;
    logic            m_ftick;
    int              m_bright;
    int              m_blink_frames;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cycles       = 0;
        m_stage        = ALL_RESET;
        m_active       = ALL_RESET;
        m_seg          = ALL_BLANK;
        m_pending      = 1'b0;
        m_ack          = 1'b0;
        m_ftick        = 1'b0;
        m_bright       = FULL;
        m_blink_frames = 0;
    endtask

    // Advance one clock: predict from the current inputs, then compare.
    task automatic step();
        bit frame_end;
        int level;
        int phase;
        bit lit;
        frame_end = (m_cycles % FRAME) == FRAME - 1;
        level     = (m_cycles / PRESCALE) % LEVELS;
        phase     = (m_blink_frames / BLINK_FRAMES) % 2;
        lit       = (m_bright == FULL) || (level < m_bright);
        for (int i = 0; i < ND; i++) begin
            m_seg[8*i +: 8] = (lit && !(blink_en && blink_mask[i] && phase == 1))
                              ? m_active[8*i +: 8] : 8'hFF;
        end
        m_ack   = frame_end && m_pending;
        m_ftick = frame_end;
        if (frame_end && m_pending) m_active = m_stage;
        if (frame_end) m_bright = int'(brightness);
        if (frame_end && blink_en) m_blink_frames++;
        if (update_req) begin
            m_stage   = seg_in;
            m_pending = 1'b1;
        end else if (frame_end) begin
            m_pending = 1'b0;
        end
        m_cycles++;
        @(posedge clk);
        #1;
        check("seg_out", 64'(seg_out), 64'(m_seg));
        check("update_ack", 64'(update_ack), 64'(m_ack));
        check("frame_tick", 64'(frame_tick), 64'(m_ftick));
        if (update_ack) ack_seen++;
    endtask

    task automatic do_reset();
        update_req = 1'b0;
        reset      = 1'b1;
        #1;
        check("reset_seg_async", 64'(seg_out), 64'(ALL_BLANK));
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_seg_held", 64'(seg_out), 64'(ALL_BLANK));
            check("reset_ack", 64'(update_ack), 64'd0);
            check("reset_ftick", 64'(frame_tick), 64'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Step until frame_tick is seen, bounded to two frames.
    task automatic wait_frame();
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 2 * FRAME);
        check("frame_tick_seen", 64'(frame_tick), 64'd1);
    endtask

    initial begin
        logic [63:0]     r;
        logic [8*ND-1:0] val_a;
        logic [8*ND-1:0] val_b;
        int              a0;
        int              lit_cnt;
        int              blank0;
        int              blank1;

        #2;
        do_reset();

        // Release: reset pattern appears after one clock and stays static.
        step();
        check("release_seg", 64'(seg_out), 64'(ALL_RESET));
        repeat (8) step();

        // Single update at cycle 10, committed at the first frame boundary.
        r      = {$urandom(), $urandom()};
        seg_in = {r[39:0], 8'h79};
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        a0 = ack_seen;
        while (m_cycles < FRAME + 2) step();
        check("commit_ack_count", 64'(ack_seen - a0), 64'd1);
        check("commit_digit0", 64'(seg_out[7:0]), 64'h79);
        check("commit_snapshot", 64'(seg_out), 64'(seg_in));

        // Brightness 4: lit for 16 of 64 cycles.
        brightness = 4'd4;
        wait_frame();
        lit_cnt = 0;
        repeat (FRAME) begin
            step();
            if (seg_out[7:0] != 8'hFF) lit_cnt++;
        end
        check("bright4_lit_cycles", 64'(lit_cnt), 64'd16);

        // Brightness 0: constantly blank after the next boundary.
        brightness = 4'd0;
        wait_frame();
        repeat (FRAME) step();
        check("bright0_blank", 64'(seg_out), 64'(ALL_BLANK));

        // Blink digit 0 at full brightness.
        brightness = 4'hF;
        blink_en   = 1'b1;
        blink_mask = 6'b000001;
        wait_frame();
        blank0 = 0;
        blank1 = 0;
        repeat (4 * FRAME) begin
            step();
            if (seg_out[7:0] == 8'hFF) blank0++;
            if (seg_out[15:8] == 8'hFF) blank1++;
        end
        check("blink_digit0_blank", 64'(blank0), 64'(2 * FRAME));
        check("blink_digit1_blank", 64'(blank1), 64'd0);
        blink_en = 1'b0;

        // Value A pending, value B requested exactly on the boundary.
        r      = {$urandom(), $urandom()};
        val_a  = r[47:0];
        r      = {$urandom(), $urandom()};
        val_b  = r[47:0] ^ 48'h1;
        seg_in = val_a;
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        begin
            int n = 0;
            while ((m_cycles % FRAME) != FRAME - 1 && n < FRAME) begin
                step();
                n++;
            end
        end
        a0 = ack_seen;
        seg_in = val_b;
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        step();
        check("ab_first_value", 64'(seg_out), 64'(val_a));
        check("ab_first_ack", 64'(ack_seen - a0), 64'd1);
        repeat (FRAME) step();
        check("ab_second_value", 64'(seg_out), 64'(val_b));
        check("ab_second_ack", 64'(ack_seen - a0), 64'd2);

        // Request then reset before the boundary: discarded, no ack.
        r      = {$urandom(), $urandom()};
        seg_in = r[47:0];
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        repeat (3) step();
        do_reset();
        a0 = ack_seen;
        step();
        check("abort_release_seg", 64'(seg_out), 64'(ALL_RESET));
        repeat (FRAME + 4) step();
        check("abort_no_ack", 64'(ack_seen - a0), 64'd0);
        check("abort_not_shown", 64'(seg_out), 64'(ALL_RESET));

        // Randomized traffic.
        repeat (2000) begin
            r          = {$urandom(), $urandom()};
            seg_in     = r[47:0];
            update_req = ($urandom_range(0, 15) == 0);
            brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 49) == 0) blink_mask = 6'($urandom_range(0, 63));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
